// File: rtl/mini_alu_arbiter.sv
// Round-robin sharing of one combinational mini_ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-port grant counters.
module mini_alu_arbiter #(
  parameter int DATA_W        = 6,
  parameter int FXN_W         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FXN_W-1:0]  req0_fxn,
  input  logic [FXN_W-1:0]  req1_fxn,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FXN_W-1:0]  alu_fxn,
  input  logic [DATA_W-1:0] alu_out
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       last_grant;
  logic       win;
  logic       accept;
  logic       last_settle;
  logic       resp_done;

  // Round-robin: on contention the port that did not win last time goes.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  assign accept      = (state == IDLE) && (req_valid != 2'b00);
  assign last_settle = (cnt == SETTLE);
  assign resp_done   = resp_ready[last_grant];

  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (state == RESP) begin
      resp_valid = last_grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (last_settle) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (resp_done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fxn    <= '0;
      resp_data  <= '0;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_a      <= win ? req1_a : req0_a;
        alu_b      <= win ? req1_b : req0_b;
        alu_fxn    <= win ? req1_fxn : req0_fxn;
        last_grant <= win;
        cnt        <= 4'd1;
      end
      // ALU inputs have been stable for SETTLE cycles on the last pass.
      if (state == ISSUE) begin
        if (last_settle) begin
          resp_data <= alu_out;
          cnt       <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else if (accept) begin
      if (!win && grant_cnt0 != 8'hFF) begin
        grant_cnt0 <= grant_cnt0 + 8'd1;
      end
      if (win && grant_cnt1 != 8'hFF) begin
        grant_cnt1 <= grant_cnt1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mini_alu_arbiter.sv
// Bench for mini_alu_arbiter with a behavioural mini_ALU on the alu_* ports.
// Scoreboard is filled on accept and drained on each response handshake.
module tb_mini_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req0_a, req1_a, req0_b, req1_b;
  logic [2:0] req0_fxn, req1_fxn;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [5:0] resp_data;
  logic [5:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_fxn;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  mini_alu_arbiter #(
    .DATA_W(6),
    .FXN_W(3),
    .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req0_a(req0_a),
    .req1_a(req1_a),
    .req0_b(req0_b),
    .req1_b(req1_b),
    .req0_fxn(req0_fxn),
    .req1_fxn(req1_fxn),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_fxn(alu_fxn),
    .alu_out(alu_out)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_f(input logic [5:0] a,
                                       input logic [5:0] b,
                                       input logic [2:0] f);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~a;
      3'd5:    return a << 1;
      3'd6:    return a + b;
      default: return a - b;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_a, alu_b, alu_fxn);

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] f;
  } cmd_t;

  typedef struct packed {
    logic       p;
    logic [5:0] d;
  } want_t;

  int    compares = 0;
  int    fails    = 0;
  want_t sb[$];
  int    order[$];
  cmd_t  q0[$];
  cmd_t  q1[$];
  logic  m_last = 1'b1;
  logic  mw;
  want_t me;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    compares++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference arbiter model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_last = 1'b1;
    end else begin
      if (req_ready != 2'b00) begin
        chk("ready_needs_valid", 32'(req_valid != 2'b00), 1);
        mw = (req_valid == 2'b11) ? !m_last : req_valid[1];
        chk("grant", 32'(req_ready), mw ? 2'b10 : 2'b01);
        me.p = mw;
        me.d = mw ? alu_f(req1_a, req1_b, req1_fxn)
                  : alu_f(req0_a, req0_b, req0_fxn);
        sb.push_back(me);
        order.push_back(int'(mw));
        m_last = mw;
      end
      if (resp_valid != 2'b00) begin
        chk("resp_onehot", 32'(resp_valid != 2'b11), 1);
      end
      for (int p = 0; p < 2; p++) begin
        if (resp_valid[p] && resp_ready[p]) begin
          chk("resp_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("resp_port", 32'(p), 32'(me.p));
            chk("resp_data", 32'(resp_data), 32'(me.d));
          end
        end
      end
    end
  end

  task automatic load();
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin
      req0_a   = q0[0].a;
      req0_b   = q0[0].b;
      req0_fxn = q0[0].f;
    end
    if (q1.size() != 0) begin
      req1_a   = q1[0].a;
      req1_b   = q1[0].b;
      req1_fxn = q1[0].f;
    end
  endtask

  task automatic run(input int budget);
    int         cyc = 0;
    logic [1:0] acc;
    load();
    while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      load();
      cyc++;
    end
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_in_budget", 32'(cyc < budget), 1);
    q0.delete();
    q1.delete();
    req_valid = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hi(input bit rsp, input int p, input string tag);
    int n   = 0;
    bit hit = 0;
    while (!hit && n < 50) begin
      @(negedge clk);
      hit = rsp ? resp_valid[p] : req_ready[p];
      n++;
    end
    chk(tag, 32'(hit), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  cmd_t       c;
  logic [5:0] hold;

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    req0_a = '0; req0_b = '0; req0_fxn = '0;
    req1_a = '0; req1_b = '0; req1_fxn = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_fxn", 32'(alu_fxn), 0);
    chk("rst_resp_data", 32'(resp_data), 0);

    // 1: single add on port 0
    req_valid = 2'b01;
    req0_a = 6'b001001; req0_b = 6'b001001; req0_fxn = 3'b110;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_issue_valid", 32'(resp_valid), 0);
    chk("t1_alu_a", 32'(alu_a), 6'b001001);
    chk("t1_alu_fxn", 32'(alu_fxn), 3'b110);
    @(negedge clk);
    chk("t1_resp_valid", 32'(resp_valid), 2'b01);
    chk("t1_resp_data", 32'(resp_data), 6'b010010);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_resp_done", 32'(resp_valid), 0);
    @(posedge clk);
    #1;

    // 2: both valid right after reset, port 0 first
    do_reset();
    order.delete();
    q0.push_back(cmd_t'{a: 6'b000101, b: 6'b000010, f: 3'd7});
    q1.push_back(cmd_t'{a: 6'b001001, b: 6'b001001, f: 3'd3});
    run(100);
    chk("t2_count", 32'(order.size()), 2);
    if (order.size() == 2) begin
      chk("t2_first", 32'(order[0]), 0);
      chk("t2_second", 32'(order[1]), 1);
    end

    // 3: both continuously valid, grants alternate
    order.delete();
    for (int i = 0; i < 4; i++) begin
      c.a = 6'($urandom); c.b = 6'($urandom); c.f = 3'(i);
      q0.push_back(c);
      c.a = 6'($urandom); c.b = 6'($urandom); c.f = 3'(i + 4);
      q1.push_back(c);
    end
    run(200);
    chk("t3_count", 32'(order.size()), 8);
    for (int i = 0; i < order.size(); i++) begin
      chk("t3_alternate", 32'(order[i]), 32'(i % 2));
    end

    // 4: response back-pressure, port 0 waiting meanwhile
    resp_ready = 2'b00;
    req_valid = 2'b10;
    req1_a = 6'd20; req1_b = 6'd3; req1_fxn = 3'd1;
    wait_hi(0, 1, "t4_accept");
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req0_a = 6'd1; req0_b = 6'd2; req0_fxn = 3'd2;
    wait_hi(1, 1, "t4_resp");
    hold = resp_data;
    chk("t4_data", 32'(hold), 6'b010111);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(resp_valid), 2'b10);
      chk("t4_hold_data", 32'(resp_data), 32'(hold));
      chk("t4_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 2'b01;
    @(negedge clk);
    chk("t4_other_ready_ignored", 32'(resp_valid), 2'b10);
    @(posedge clk);
    #1;
    resp_ready = 2'b11;
    q0.push_back(cmd_t'{a: 6'd1, b: 6'd2, f: 3'd2});
    run(100);

    // 5: reset while in ISSUE drops the command
    req_valid = 2'b01;
    req0_a = 6'd3; req0_b = 6'd4; req0_fxn = 3'd6;
    wait_hi(0, 0, "t5_accept");
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_resp_valid", 32'(resp_valid), 0);
    chk("t5_alu_a", 32'(alu_a), 0);
    chk("t5_alu_b", 32'(alu_b), 0);
    chk("t5_alu_fxn", 32'(alu_fxn), 0);
    chk("t5_resp_data", 32'(resp_data), 0);
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_resp", 32'(resp_valid), 0);
    end
    @(posedge clk);
    #1;

`ifdef ALU_ARB_STATS_EN
    // 6: grant counters saturate
    do_reset();
    chk("t6_rst_cnt0", 32'(grant_cnt0), 0);
    chk("t6_rst_cnt1", 32'(grant_cnt1), 0);
    for (int i = 0; i < 300; i++) begin
      c.a = 6'($urandom); c.b = 6'($urandom); c.f = 3'($urandom);
      q0.push_back(c);
    end
    for (int i = 0; i < 3; i++) begin
      c.a = 6'($urandom); c.b = 6'($urandom); c.f = 3'($urandom);
      q1.push_back(c);
    end
    run(5000);
    chk("t6_cnt0", 32'(grant_cnt0), 8'hFF);
    chk("t6_cnt1", 32'(grant_cnt1), 8'h03);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
